// File: rtl/router_pkg.sv
// Shared router message definitions: header layout, full message layout and reserved message types.
package router_pkg;

   localparam int ROUTER_BUS_W = 64;
   localparam int ROUT_HDR_W   = 24;
   localparam logic [7:0] MTYPE_NULL = 8'h00;

   typedef struct packed {
      logic [3:0] src_x;
      logic [3:0] src_y;
      logic [3:0] dst_x;
      logic [3:0] dst_y;
      logic [7:0] mtype;
   } rout_hdr_t;

   typedef struct packed {
      rout_hdr_t                               hdr;
      logic [ROUTER_BUS_W-ROUT_HDR_W-1:0]      data;
   } rout_msg_t;

endpackage

// File: rtl/router_msg_fifo.sv
// First-word-fall-through message FIFO with registered storage; shared by the NI receive and transmit sides.
module router_msg_fifo #(
   parameter int WIDTH = 56,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage is cleared on reset so the head fields read as zero afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/router_ni_rx.sv
// NI receive endpoint: checks destination of router messages, buffers local ones and hands them to the core.
module router_ni_rx
   import router_pkg::*;
#(
   parameter int BUS_W = 64,
   parameter int DEPTH = 4,
   parameter int LOC_X = 0,
   parameter int LOC_Y = 0,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic [BUS_W-1:0]      s_tdata,
   input  logic                  s_tlast,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [3:0]            m_src_x,
   output logic [3:0]            m_src_y,
   output logic [7:0]            m_mtype,
   output logic [BUS_W-25:0]     m_data,
   output logic [CNT_W-1:0]      drop_cnt,
   output logic                  misroute,
   output logic                  proto_err
);

   localparam int PAY_W  = BUS_W - ROUT_HDR_W;
   localparam int FIFO_W = PAY_W + 16;
   localparam int AW     = $clog2(DEPTH);

   rout_hdr_t         hdr;
   logic [PAY_W-1:0]  pay;
   logic              rdy_en;
   logic              accept;
   logic              dst_match;
   logic              push;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FIFO_W-1:0] fifo_din;
   logic [FIFO_W-1:0] fifo_dout;
   logic [AW:0]       unused_count;

   assign hdr = rout_hdr_t'(s_tdata[BUS_W-1 -: ROUT_HDR_W]);
   assign pay = s_tdata[PAY_W-1:0];

   // Ready never looks at s_tvalid; a pop while full only frees space for the next cycle.
   assign s_tready  = rdy_en && !fifo_full;
   assign accept    = s_tvalid && s_tready;
   assign dst_match = (hdr.dst_x == 4'(LOC_X)) && (hdr.dst_y == 4'(LOC_Y));
   assign push      = accept && dst_match && (hdr.mtype != MTYPE_NULL);
   assign fifo_din  = {hdr.src_x, hdr.src_y, hdr.mtype, pay};

   router_msg_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (fifo_din),
      .full  (fifo_full),
      .pop   (m_valid && m_ready),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .count (unused_count)
   );

   assign m_valid = !fifo_empty;
   assign {m_src_x, m_src_y, m_mtype, m_data} = fifo_dout;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en    <= 1'b0;
         misroute  <= 1'b0;
         drop_cnt  <= '0;
         proto_err <= 1'b0;
      end else begin
         rdy_en   <= 1'b1;
         misroute <= accept && !dst_match;
         if (accept && !dst_match && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
         if (accept && !s_tlast) proto_err <= 1'b1;
      end
   end

endmodule

// File: doc/router_ni_rx.md
Name: router_ni_rx

Overview:
- Network-interface receive endpoint: the sink side of the router local-port AXI-stream that carries router messages.
- Accepts single-beat router messages and checks that the destination coordinates match this tile.
- Buffers valid messages in a small FIFO and presents the decoded fields (src, mtype, data) to the local core over a valid/ready handshake.
- Sits between a router's local output port and the tile core; it is the counterpart of the NI transmit side that builds messages.

Parameters:
- BUS_W, 64, router bus width (equals ROUTER_BUS_W); payload width is BUS_W-24.
- DEPTH, 4, FIFO depth in messages; power of 2, at least 2.
- LOC_X, 0, this tile's 4-bit X coordinate.
- LOC_Y, 0, this tile's 4-bit Y coordinate.
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- s_tvalid  in  1  router message valid.
- s_tready  out  1  NI can accept a message.
- s_tdata  in  BUS_W  router message, packed as follows, MSB first:
  - src_x[4]
  - src_y[4]
  - dst_x[4]
  - dst_y[4]
  - mtype[8]
  - data[BUS_W-24]
- s_tlast  in  1  end of message; must be 1 on every beat.
- m_valid  out  1  decoded message available to the core.
- m_ready  in  1  core accepts the message.
- m_src_x  out  4  source X of the head message.
- m_src_y  out  4  source Y of the head message.
- m_mtype  out  8  message type of the head message.
- m_data  out  BUS_W-24  payload of the head message.
- drop_cnt  out  CNT_W  saturating count of dropped messages.
- misroute  out  1  one-cycle pulse when a beat with dst != (LOC_X,LOC_Y) is accepted.
- proto_err  out  1  sticky flag, set when a beat is accepted with s_tlast=0.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst is asynchronous, active-high, and fully clears state.
  - Reset values: s_tready=0 while rst is high; after rst falls, s_tready=1 from the next rising edge.
  - All other outputs reset to 0: m_valid, m_* fields, drop_cnt, misroute, proto_err.
  - Reset mid-operation discards all FIFO contents and counters; no partial state survives.
- Accept handshake:
  - A beat is accepted on a rising edge with s_tvalid && s_tready.
  - s_tready = !full, registered-free, so it depends only on FIFO state and never on s_tvalid.
  - While full, s_tready=0 even if a pop happens in the same cycle (no pass-through); it rises the cycle after the pop.
- Classification of an accepted beat (combinational decode, registered effect):
  - dst match and mtype != 8'h00: push into the FIFO.
  - dst match and mtype == 8'h00 (NULL/idle): discard; no count, no pulse.
  - dst mismatch: discard; misroute=1 for exactly the following cycle; drop_cnt += 1.
  - s_tlast=0: proto_err is set and held until rst. The beat is still classified as above.
- Drop counter: drop_cnt saturates at all-ones and does not wrap.
- Output side:
  - FIFO is first-word-fall-through with registered storage.
  - A message pushed on edge N gives m_valid=1 with its fields stable after edge N, i.e. 1-cycle latency.
  - Pop happens on a rising edge with m_valid && m_ready.
  - m_* fields hold stable while m_valid && !m_ready.
  - m_* fields are don't-care when m_valid=0; the RTL holds the last value.
- Simultaneous push and pop:
  - Allowed when not full.
  - Occupancy is unchanged and order is preserved.
  - When occupancy is 1, the new message becomes the head on the next cycle.
- Pointers and occupancy:
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy counter is log2(DEPTH)+1 bits.
  - full = (count == DEPTH); empty = (count == 0).
- State machine: none beyond the FIFO. The classification path is a single registered stage, with no stall other than full.

Decomposition:
- router_pkg (shared package) gains:
  - rout_msg_t, reused as-is for field extraction: cast s_tdata to rout_msg_t.
  - localparam MTYPE_NULL = 8'h00.
  - localparam ROUT_HDR_W = 24.
- One sub-module: router_msg_fifo.
  - Parameterised width and depth; FWFT; async active-high reset.
  - Ports: push, din, full, pop, dout, empty, count.
  - The NI transmit side reuses it.

Test Plan (BUS_W=64, LOC_X=2, LOC_Y=3, DEPTH=4):
1. Single match: s_tdata = {4'h1,4'h1,4'h2,4'h3,8'h05,40'hAB_CDEF_0123}, tlast=1, m_ready=1 → m_valid=1 the cycle after accept, with m_src_x=1, m_src_y=1, m_mtype=05, m_data=AB_CDEF_0123; drop_cnt=0.
2. Misroute: dst=(4,3), mtype=05 → no m_valid, misroute pulses for exactly 1 cycle, drop_cnt=1. Then 3 more misroutes → drop_cnt=4.
3. Backpressure/full:
   - m_ready=0, push 5 matching messages with data 1..5 → s_tready drops after the 4th accept; 5th is held by the source.
   - Raise m_ready for 1 cycle → data 1 pops, s_tready returns next cycle, 5th is accepted.
   - Drain order is 2,3,4,5.
4. NULL and protocol error:
   - mtype=00 matching → discarded, no misroute, drop_cnt unchanged.
   - A matching beat with tlast=0, mtype=07 → stored and delivered, proto_err=1 and stays 1.
5. Simultaneous push/pop at occupancy 1 with continuous streaming (s_tvalid=1, m_ready=1, 10 messages) → one delivery per cycle, in order, no bubbles after the first; pointers wrap correctly.
6. Reset mid-operation: FIFO holding 3 messages and drop_cnt=2, assert rst asynchronously between edges → m_valid, drop_cnt, proto_err and misroute go to 0 immediately. After release, s_tready=1 and no stale message appears.
